// File: rtl/uart_tx_frame_module.sv
// uart_tx_frame_module: UART transmitter with an internal baud counter.
// Accepts one byte per valid/ready handshake and sends it as a frame:
// start bit, LSB-first data bits, optional parity bit, then stop bit(s).
// Ports:
//   CLK        - system clock, rising edge
//   RSTn       - asynchronous active-low reset
//   TX_Valid   - a byte is offered on TX_Data
//   TX_Data    - byte to send; bits above DATA_BITS-1 are ignored
//   TX_Ready   - a byte can be accepted this cycle
//   TX_Done    - one-cycle pulse on the first idle cycle after a frame
//   TX_Busy    - a frame is on the line
//   TX_Pin_Out - serial line, idles high, driven straight from a flop
module uart_tx_frame_module #(
    parameter int CLKS_PER_BIT = 1736,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       TX_Valid,
    input  logic [7:0] TX_Data,
    output logic       TX_Ready,
    output logic       TX_Done,
    output logic       TX_Busy,
    output logic       TX_Pin_Out
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [11:0] last_cnt  = 12'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  last_data = 3'(DATA_BITS - 1);
    localparam logic [2:0]  last_stop = 3'(STOP_BITS - 1);
    localparam logic [7:0]  data_mask = 8'((1 << DATA_BITS) - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 4095 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx_frame_module: parameter out of legal range");
    end

    state_t      state, state_n;
    logic [11:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic [7:0]  shreg, sh_n;
    logic        par, par_n;
    logic        pin, pin_n;
    logic        done, done_n;
    logic        strobe;

    assign strobe     = cnt == last_cnt;
    assign TX_Ready   = state == IDLE;
    assign TX_Busy    = state != IDLE;
    assign TX_Done    = done;
    assign TX_Pin_Out = pin;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            pin   <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= sh_n;
            par   <= par_n;
            pin   <= pin_n;
            done  <= done_n;
        end
    end

    // The parity bit is computed at capture because the shift register is
    // consumed while the data bits go out. idx counts data bits in DATA and
    // stop bits in STOP.
    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || strobe) ? '0 : cnt + 12'd1;
        idx_n   = idx;
        sh_n    = shreg;
        par_n   = par;
        done_n  = 1'b0;
        case (state)
            IDLE: if (TX_Valid) begin
                state_n = START;
                sh_n    = TX_Data & data_mask;
                par_n   = ^(TX_Data & data_mask) ^ 1'(PARITY_ODD);
            end
            START: if (strobe) begin
                state_n = DATA;
                idx_n   = '0;
            end
            DATA: if (strobe) begin
                sh_n  = shreg >> 1;
                idx_n = (idx == last_data) ? '0 : idx + 3'd1;
                if (idx == last_data) state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (strobe) state_n = STOP;
            STOP: if (strobe) begin
                idx_n = (idx == last_stop) ? '0 : idx + 3'd1;
                if (idx == last_stop) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // Line level follows the next state so the start bit appears on the
        // acceptance edge and every bit lasts exactly CLKS_PER_BIT cycles.
        pin_n = (state_n == START)  ? 1'b0 :
                (state_n == DATA)   ? sh_n[0] :
                (state_n == PARITY) ? par_n : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_frame_module.sv
// tb_uart_tx_frame_module: frame-level model and directed tests for the UART transmitter.
module tb_uart_tx_frame_module;
    localparam int CPB [5] = '{1736, 16, 16, 4, 16};
    localparam int DB  [5] = '{8, 8, 8, 7, 8};
    localparam int PE  [5] = '{0, 1, 1, 0, 0};
    localparam int PO  [5] = '{0, 0, 1, 0, 0};
    localparam int SB  [5] = '{1, 1, 1, 2, 1};

    logic       clk = 1'b0;
    logic [4:0] rstn = '0;
    logic [4:0] valid = '0;
    logic [7:0] data [5];
    logic [4:0] ready, done, busy, pin;
    int         cyc = 0;
    int         tests = 0, fails = 0, ctests = 0, cfails = 0;
    int         dcnt [5] = '{default: 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_frame_module u0 (.CLK(clk), .RSTn(rstn[0]), .TX_Valid(valid[0]), .TX_Data(data[0]),
        .TX_Ready(ready[0]), .TX_Done(done[0]), .TX_Busy(busy[0]), .TX_Pin_Out(pin[0]));
    uart_tx_frame_module #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (.CLK(clk),
        .RSTn(rstn[1]), .TX_Valid(valid[1]), .TX_Data(data[1]), .TX_Ready(ready[1]),
        .TX_Done(done[1]), .TX_Busy(busy[1]), .TX_Pin_Out(pin[1]));
    uart_tx_frame_module #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (.CLK(clk),
        .RSTn(rstn[2]), .TX_Valid(valid[2]), .TX_Data(data[2]), .TX_Ready(ready[2]),
        .TX_Done(done[2]), .TX_Busy(busy[2]), .TX_Pin_Out(pin[2]));
    uart_tx_frame_module #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) u3 (.CLK(clk),
        .RSTn(rstn[3]), .TX_Valid(valid[3]), .TX_Data(data[3]), .TX_Ready(ready[3]),
        .TX_Done(done[3]), .TX_Busy(busy[3]), .TX_Pin_Out(pin[3]));
    uart_tx_frame_module #(.CLKS_PER_BIT(16)) u4 (.CLK(clk), .RSTn(rstn[4]), .TX_Valid(valid[4]),
        .TX_Data(data[4]), .TX_Ready(ready[4]), .TX_Done(done[4]), .TX_Busy(busy[4]),
        .TX_Pin_Out(pin[4]));

    function automatic int flen(int i);
        return (1 + DB[i] + PE[i] + SB[i]) * CPB[i];
    endfunction

    // Frame as a bit list: index 0 is the start bit; unused tail reads as stop level.
    function automatic logic [11:0] frame(int i, logic [7:0] d);
        logic [11:0] f;
        logic        p;
        f    = '1;
        p    = PO[i] != 0;
        f[0] = 1'b0;
        for (int k = 0; k < DB[i]; k++) begin
            f[k + 1] = d[k];
            p = p ^ d[k];
        end
        if (PE[i] != 0) f[DB[i] + 1] = p;
        return f;
    endfunction

    function automatic logic [7:0] dec(logic [11:0] rec, int nbits);
        logic [7:0] d;
        d = '0;
        for (int k = 0; k < nbits; k++) d[k] = rec[k + 1];
        return d;
    endfunction

    // Model: t = cycles since the acceptance edge (-1 when idle); the line shows frame bit t/CPB.
    int          t  [5] = '{default: -1};
    logic [11:0] fr [5];
    logic [4:0]  dn = '0;

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (!rstn[i]) begin
                t[i]  <= -1;
                dn[i] <= 1'b0;
            end else if (t[i] >= 0) begin
                t[i]  <= (t[i] + 1 == flen(i)) ? -1 : t[i] + 1;
                dn[i] <= (t[i] + 1 == flen(i));
            end else begin
                dn[i] <= 1'b0;
                if (valid[i]) begin
                    t[i]  <= 0;
                    fr[i] <= frame(i, data[i]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            logic [3:0] act, exp;
            act = {pin[i], ready[i], busy[i], done[i]};
            if (!rstn[i]) exp = 4'b1100;
            else if (t[i] < 0) exp = {3'b110, dn[i]};
            else exp = {fr[i][t[i] / CPB[i]], 3'b010};
            ctests++;
            if (act !== exp) begin
                cfails++;
                $display("FAIL cycle u%0d @%0d pin/ready/busy/done: got %b want %b", i, cyc, act, exp);
            end
            if (done[i]) dcnt[i]++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input int i, input logic [7:0] d);
        @(negedge clk);
        valid[i] = 1'b1;
        data[i]  = d;
        @(negedge clk);
        valid[i] = 1'b0;
    endtask

    // Receiver: finds the start bit, samples each bit centre, measures fall-to-done
    // length and counts high cycles in the stop region.
    task automatic rx(input int i, output logic [11:0] rec, output int len, output int hi,
                      output int fall_at);
        int c, sc;
        c   = CPB[i];
        sc  = (1 + DB[i] + PE[i]) * c;
        rec = '1;
        len = -1;
        hi  = 0;
        fall_at = -1;
        for (int w = 0; w < 200 && fall_at < 0; w++) begin
            if (pin[i] == 1'b0) fall_at = cyc;
            else @(negedge clk);
        end
        if (fall_at < 0) begin
            tests++;
            fails++;
            $display("FAIL rx u%0d start: got no start bit want one within 200 cycles", i);
        end else begin
            for (int n = 0; n <= 2 * flen(i) && len < 0; n++) begin
                if (n > 0) @(negedge clk);
                if (n % c == c / 2 && n / c < 12) rec[n / c] = pin[i];
                if (done[i]) len = n;
                else if (n >= sc && pin[i]) hi++;
            end
            if (len < 0) begin
                tests++;
                fails++;
                $display("FAIL rx u%0d done: got no TX_Done want one within %0d cycles", i, 2 * flen(i));
            end
        end
    endtask

    initial begin
        logic [11:0] r1, r2;
        int l1, l2, h1, h2, f1, f2, d0;
        for (int i = 0; i < 5; i++) data[i] = 8'h00;
        @(negedge clk);
        chk("reset pin", pin[0], 1);
        chk("reset ready", ready[0], 1);
        chk("reset busy", busy[0], 0);
        chk("reset done", done[0], 0);
        repeat (2) @(negedge clk);
        rstn = '1;
        repeat (2) @(negedge clk);

        // defaults, 0x55
        send(0, 8'h55);
        rx(0, r1, l1, h1, f1);
        chk("t1 bit centres", int'(r1[9:0]), int'(10'b1010101010));
        chk("t1 frame length", l1, 17360);
        chk("t1 byte", dec(r1, 8), 8'h55);

        // parity even then odd, 0x07
        send(1, 8'h07);
        rx(1, r1, l1, h1, f1);
        chk("t2 even parity bit", r1[9], 1);
        chk("t2 even frame length", l1, 176);
        chk("t2 even byte", dec(r1, 8), 8'h07);
        send(2, 8'h07);
        rx(2, r1, l1, h1, f1);
        chk("t2 odd parity bit", r1[9], 0);
        chk("t2 odd frame length", l1, 176);

        // back-to-back 0xA5, 0x3C with TX_Valid held
        @(negedge clk);
        valid[4] = 1'b1;
        data[4]  = 8'hA5;
        fork
            begin
                repeat (20) @(negedge clk);
                data[4] = 8'h3C;
                for (int w = 0; w < 400 && !done[4]; w++) @(negedge clk);
                @(negedge clk);
                valid[4] = 1'b0;
            end
            begin
                rx(4, r1, l1, h1, f1);
                rx(4, r2, l2, h2, f2);
            end
        join
        chk("t3 first byte", dec(r1, 8), 8'hA5);
        chk("t3 second byte", dec(r2, 8), 8'h3C);
        chk("t3 first length", l1, 160);
        chk("t3 second length", l2, 160);
        chk("t3 no idle gap", f2, f1 + 161);

        // busy ignore and capture
        repeat (5) @(negedge clk);
        d0 = dcnt[4];
        @(negedge clk);
        valid[4] = 1'b1;
        data[4]  = 8'hF0;
        fork
            begin
                @(negedge clk);
                valid[4] = 1'b0;
                repeat (30) @(negedge clk);
                valid[4] = 1'b1;
                data[4]  = 8'h11;
                @(negedge clk);
                valid[4] = 1'b0;
                repeat (30) @(negedge clk);
                data[4] = 8'h00;
            end
            rx(4, r1, l1, h1, f1);
        join
        repeat (200) @(negedge clk);
        chk("t4 byte", dec(r1, 8), 8'hF0);
        chk("t4 done count", dcnt[4] - d0, 1);
        chk("t4 idle after", busy[4], 0);

        // reset during data bit 3 of 0x81
        d0 = dcnt[4];
        send(4, 8'h81);
        repeat (4 * 16 + 8) @(negedge clk);
        chk("t5 line low before reset", pin[4], 0);
        #2 rstn[4] = 1'b0;
        #1;
        chk("t5 pin on reset", pin[4], 1);
        chk("t5 ready on reset", ready[4], 1);
        chk("t5 busy on reset", busy[4], 0);
        repeat (3) @(negedge clk);
        rstn[4] = 1'b1;
        repeat (200) @(negedge clk);
        chk("t5 no done", dcnt[4] - d0, 0);
        send(4, 8'h81);
        rx(4, r1, l1, h1, f1);
        chk("t5 byte after reset", dec(r1, 8), 8'h81);
        chk("t5 length after reset", l1, 160);

        // 4 clocks/bit, 7 data bits, 2 stop bits, 0x7F
        send(3, 8'h7F);
        rx(3, r1, l1, h1, f1);
        chk("t6 frame length", l1, 40);
        chk("t6 stop high cycles", h1, 8);
        chk("t6 start bit", r1[0], 0);
        chk("t6 byte", dec(r1, 7), 8'h7F);

        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests + ctests, fails + cfails);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame_module.md
Name: uart_tx_frame_module

Overview:
UART transmitter for the serial driver path. It accepts one byte through a valid/ready handshake and serialises it on the TX line as a frame: start bit, LSB-first data bits, optional parity, then stop bit(s). Bit timing comes from an internal baud counter, so no separate bps module is needed. Default timing is 1736 clocks per bit (28800 baud at 50 MHz), matching the receive path.

Parameters:
CLKS_PER_BIT, 1736, clock cycles per serial bit; legal range 2..4095.
DATA_BITS, 8, data bits per frame; legal range 5..8.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
CLK  input  1  system clock; all logic is on the rising edge.
RSTn  input  1  reset, asynchronous, active-low.
TX_Valid  input  1  a byte is offered on TX_Data.
TX_Data  input  8  byte to send; bits above DATA_BITS-1 are ignored.
TX_Ready  output  1  the block can accept a byte this cycle.
TX_Done  output  1  one-cycle pulse when a frame's last stop bit completes.
TX_Busy  output  1  high while a frame is on the line.
TX_Pin_Out  output  1  serial line; idles high.

Behaviour:
- Reset values (asynchronous, immediate): TX_Pin_Out=1, TX_Ready=1, TX_Done=0, TX_Busy=0, FSM=IDLE, baud counter=0, bit index=0.
- Handshake:
  - Acceptance happens on a rising edge where TX_Valid=1 and TX_Ready=1.
  - TX_Data is captured into a shift register at that edge. Later changes to TX_Data have no effect on the frame.
  - TX_Valid while TX_Ready=0 is ignored. Nothing is queued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_Pin_Out=1, TX_Ready=1, TX_Busy=0. On acceptance go to START and clear the baud counter.
  - START: TX_Pin_Out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: TX_Pin_Out = shift register bit 0. Each bit lasts CLKS_PER_BIT cycles. At each bit end, shift right and increment the index. After bit DATA_BITS-1, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: TX_Pin_Out = XOR of the DATA_BITS data bits, XOR PARITY_ODD. Lasts CLKS_PER_BIT cycles, then go to STOP.
  - STOP: TX_Pin_Out=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter: 12 bits. Counts 0..CLKS_PER_BIT-1 while not in IDLE. The bit-end strobe is count==CLKS_PER_BIT-1; the counter wraps to 0 on that strobe. The counter is held at 0 in IDLE.
- Latency and frame length:
  - TX_Pin_Out falls on the first edge after acceptance (1-cycle latency).
  - Frame length is exactly (1 + DATA_BITS + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles, measured from the TX_Pin_Out fall to the cycle TX_Done is asserted.
  - TX_Busy=1 and TX_Ready=0 from the cycle after acceptance until the end of STOP.
- Completion:
  - TX_Done pulses for exactly one cycle, on the first cycle back in IDLE. TX_Ready is 1 in that same cycle.
  - Back-to-back: if TX_Valid=1 in the TX_Done cycle, that byte is accepted. The next start bit follows the previous stop bit with zero idle cycles.
- Glitch-free output: TX_Pin_Out is driven directly from a flop (no combinational output path).
- Reset mid-frame: the line returns high at once and the frame is abandoned. No TX_Done is generated. The first acceptance after reset release starts a clean frame.
- Parameter sanity: elaboration fails (generate/initial check) if a parameter is outside its legal range.

Test Plan:
1. Defaults, send 0x55:
   - TX_Pin_Out sampled at each bit centre (offset 868 + k*1736) reads 0,1,0,1,0,1,0,1,0,1.
   - TX_Done appears exactly 17360 cycles after the falling edge.
2. PARITY_EN=1, PARITY_ODD=0, send 0x07:
   - parity bit = 1; frame is 11 bits = 19096 cycles.
   - With PARITY_ODD=1 the parity bit = 0.
3. Back-to-back 0xA5 then 0x3C, TX_Valid held high:
   - the second start bit begins on the cycle after TX_Done with no idle gap.
   - The decoded stream is 0xA5, 0x3C.
4. Busy ignore and data capture:
   - Accept 0xF0, then pulse TX_Valid with 0x11 mid-frame and change TX_Data to 0x00 during the frame.
   - Only 0xF0 is transmitted; only one TX_Done occurs.
5. Reset mid-frame:
   - Assert RSTn=0 during data bit 3 of 0x81.
   - TX_Pin_Out=1 and TX_Ready=1 immediately; no TX_Done.
   - After release, sending 0x81 produces a correct frame.
6. CLKS_PER_BIT=4, STOP_BITS=2, DATA_BITS=7, send 0x7F:
   - Frame is (1+7+2)*4 = 40 cycles; stop level held for 8 cycles.
   - Loopback into the existing receive path returns 0x7F.
